// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard sequencer.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PEND    = 3'd4
    } state_t;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_FF = 8'hFF;

    // Keyboard status replies (BAT ok, ACK, echo, resend) carry no key information.
    function automatic logic is_status_byte(input logic [7:0] c);
        return (c == SC_AA) || (c == SC_FA) || (c == SC_EE) || (c == SC_FE);
    endfunction

    // Keyboard buffer overrun / error codes.
    function automatic logic is_error_byte(input logic [7:0] c);
        return (c == SC_00) || (c == SC_FF);
    endfunction

endpackage

// File: rtl/ps2_seq_timeout.sv
// Idle-cycle counter used to abandon partial E0/F0 prefix sequences.
module ps2_seq_timeout
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CW             = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/secuenciador_teclado_ps2.sv
// PS/2 scan-code sequencer: decodes make/break/E0 sequences into FIFO writes with back-pressure.
// Optional build macro PS2_REPEAT_FILTER_EN discards typematic repeats of the held key.
module secuenciador_teclado_ps2
    import ps2_pkg::*;
#(
    parameter int B              = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CW             = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_done_tick,
    input  logic [B-1:0] rx_data,
    output logic         rx_en,
    input  logic         fifo_full,
    output logic         fifo_wr,
    output logic [B:0]   fifo_w_data,
    input  logic         clr_overrun,
    output logic         overrun,
    output logic         key_held
);

    state_t       r_state;
    logic         r_rx_en;
    logic         r_fifo_wr;
    logic [B:0]   r_fifo_w_data;
    logic [B:0]   r_pend;
    logic [B:0]   r_held;
    logic         r_key_held;
    logic         r_overrun;

    logic         w_is_e0;
    logic         w_is_f0;
    logic         w_is_status;
    logic         w_is_error;
    logic         w_in_prefix;
    logic         w_tmo_clr;
    logic         w_tmo_en;
    logic         w_tmo;
    logic         w_make;
    logic         w_break;
    logic [B:0]   w_event;
    logic         w_repeat;
    logic         w_ovr_set;
    logic         w_pend_entry;

    assign w_is_e0     = (rx_data == B'(SC_E0));
    assign w_is_f0     = (rx_data == B'(SC_F0));
    assign w_is_status = is_status_byte(rx_data[7:0]);
    assign w_is_error  = is_error_byte(rx_data[7:0]);

    assign w_in_prefix = (r_state == EXT) || (r_state == BRK) || (r_state == EXT_BRK);
    assign w_tmo_clr   = rx_done_tick || !w_in_prefix;
    assign w_tmo_en    = !w_tmo_clr;

    ps2_seq_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CW             (CW)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_tmo_clr),
        .i_en  (w_tmo_en),
        .o_tc  (w_tmo)
    );

    // Event decode: what the byte arriving this cycle means in the current state.
    always_comb begin
        w_make  = 1'b0;
        w_break = 1'b0;
        w_event = {1'b0, rx_data};
        if (rx_done_tick) begin
            case (r_state)
                IDLE: begin
                    w_make = !w_is_e0 && !w_is_f0 && !w_is_status && !w_is_error;
                end
                EXT: begin
                    w_make  = !w_is_f0;
                    w_event = {1'b1, rx_data};
                end
                BRK: begin
                    w_break = 1'b1;
                end
                EXT_BRK: begin
                    w_break = 1'b1;
                    w_event = {1'b1, rx_data};
                end
                default: ;
            endcase
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    assign w_repeat = r_key_held && (r_held == w_event);
`else
    assign w_repeat = 1'b0;
`endif

    // Bytes lost: error codes from the keyboard, or a byte landing while stalled.
    assign w_ovr_set    = rx_done_tick &&
                          (((r_state == IDLE) && w_is_error) || (r_state == PEND));
    assign w_pend_entry = w_make && !w_repeat && fifo_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rx_en       <= 1'b1;
            r_fifo_wr     <= 1'b0;
            r_fifo_w_data <= '0;
            r_pend        <= '0;
            r_held        <= '0;
            r_key_held    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_fifo_wr <= 1'b0;
            r_overrun <= w_ovr_set || (r_overrun && !clr_overrun);

            case (r_state)
                IDLE: begin
                    if (rx_done_tick) begin
                        if (w_is_e0) begin
                            r_state <= EXT;
                        end else if (w_is_f0) begin
                            r_state <= BRK;
                        end
                    end
                end
                EXT: begin
                    if (rx_done_tick) begin
                        r_state <= w_is_f0 ? EXT_BRK : IDLE;
                    end else if (w_tmo) begin
                        r_state <= IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    if (rx_done_tick || w_tmo) begin
                        r_state <= IDLE;
                    end
                end
                PEND: begin
                    if (!fifo_full) begin
                        r_fifo_wr     <= 1'b1;
                        r_fifo_w_data <= r_pend;
                        r_rx_en       <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rx_en <= 1'b1;
                end
            endcase

            // Key-press events; held-key tracking follows every accepted make.
            if (w_make) begin
                r_held     <= w_event;
                r_key_held <= 1'b1;
                if (!w_repeat && !fifo_full) begin
                    r_fifo_wr     <= 1'b1;
                    r_fifo_w_data <= w_event;
                end
            end

            if (w_pend_entry) begin
                r_pend  <= w_event;
                r_state <= PEND;
                r_rx_en <= 1'b0;
            end

            if (w_break && (w_event == r_held)) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign rx_en       = r_rx_en;
    assign fifo_wr     = r_fifo_wr;
    assign fifo_w_data = r_fifo_w_data;
    assign overrun     = r_overrun;
    assign key_held    = r_key_held;

endmodule
